// File: rtl/cb_row_agd.sv
// ---------------------------------------------------------------------------
// cb_row_agd -- covariance-buffer row address generator
//
// Walks a column range of one group pair and emits one buffer address per
// (column, row) beat: for col = col_start .. effective end, row 0 then row 1,
// addr = base + 2*col + row (modulo 2^CB_AW). Beats use a valid/ready
// handshake; a burst ends with a one-cycle done pulse.
//
// Optional build macro: CB_ROW_AGD_BOUND_CHECK_EN
//   defined   : col_end beyond 2*g+1 is clamped to 2*g+1 and err is raised.
//   undefined : col_end is used as given and err stays 0.
//
// Ports
//   clk          in   clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   start        in   one-cycle burst request, honoured only when idle
//   base_addr    in   [CB_AW]      group base address, 2*(g*g+g)
//   group_cnt    in   [ROW_LEN]    group index g
//   col_start    in   [ROW_LEN+1]  first column (inclusive)
//   col_end      in   [ROW_LEN+1]  last column (inclusive)
//   addr_out     out  [CB_AW]      generated address
//   row_sel      out  row of the current beat (0/1)
//   col_out      out  [ROW_LEN+1]  column of the current beat
//   addr_valid   out  beat valid
//   addr_ready   in   downstream accepts the beat
//   last         out  final beat of the burst
//   busy         out  not idle
//   done         out  one-cycle burst-complete pulse
//   err          out  sticky range error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module cb_row_agd #(
    parameter int CB_AW   = 17,
    parameter int ROW_LEN = 10
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic [CB_AW-1:0]   base_addr,
    input  logic [ROW_LEN-1:0] group_cnt,
    input  logic [ROW_LEN:0]   col_start,
    input  logic [ROW_LEN:0]   col_end,
    output logic [CB_AW-1:0]   addr_out,
    output logic               row_sel,
    output logic [ROW_LEN:0]   col_out,
    output logic               addr_valid,
    input  logic               addr_ready,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // base + 2*col + row, computed wide and truncated to the buffer width
    function automatic logic [CB_AW-1:0] calc_addr(
        input logic [CB_AW-1:0] b,
        input logic [ROW_LEN:0] c,
        input logic             r
    );
        logic [CB_AW+ROW_LEN+1:0] sum;
        sum = {{(ROW_LEN+2){1'b0}}, b}
            + {{CB_AW{1'b0}}, c, 1'b0}
            + {{(CB_AW+ROW_LEN+1){1'b0}}, r};
        return sum[CB_AW-1:0];
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CB_AW-1:0]   base_q, base_d;
    logic [ROW_LEN:0]   cs_q, cs_d;
    logic [ROW_LEN:0]   ce_q, ce_d;
    logic [ROW_LEN:0]   eff_q, eff_d;
    logic [ROW_LEN:0]   col_q, col_d;
    logic               row_q, row_d;
    logic [CB_AW-1:0]   addr_q, addr_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ROW_LEN:0]   eff_s;
    logic [ROW_LEN:0]   col_inc_s;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
    logic [ROW_LEN-1:0] grp_q, grp_d;
    logic [ROW_LEN:0]   limit_s;
`endif

    assign col_inc_s = col_q + {{ROW_LEN{1'b0}}, 1'b1};

    // Effective end column: clamped to 2*g+1 only when bound checking is built in
    always_comb begin
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
        limit_s = {grp_q, 1'b1};
        if (ce_q > limit_s) begin
            eff_s = limit_s;
        end else begin
            eff_s = ce_q;
        end
`else
        eff_s = ce_q;
`endif
    end

    // Next-state and datapath for the burst FSM
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cs_d    = cs_q;
        ce_d    = ce_q;
        eff_d   = eff_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
        grp_d   = grp_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                    base_d  = base_addr;
                    cs_d    = col_start;
                    ce_d    = col_end;
                    err_d   = 1'b0;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
                    grp_d   = group_cnt;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                eff_d = eff_s;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
                err_d = (ce_q > limit_s);
`else
                err_d = 1'b0;
`endif
                if (cs_q > eff_s) begin
                    // empty range: skip straight to completion
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    col_d   = cs_q;
                    row_d   = 1'b0;
                    addr_d  = calc_addr(base_q, cs_q, 1'b0);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (valid_q && addr_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (!row_q) begin
                        row_d  = 1'b1;
                        addr_d = calc_addr(base_q, col_q, 1'b1);
                        last_d = (col_q == eff_q);
                    end else begin
                        col_d  = col_inc_s;
                        row_d  = 1'b0;
                        addr_d = calc_addr(base_q, col_inc_s, 1'b0);
                        last_d = 1'b0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            base_q  <= {CB_AW{1'b0}};
            cs_q    <= {(ROW_LEN+1){1'b0}};
            ce_q    <= {(ROW_LEN+1){1'b0}};
            eff_q   <= {(ROW_LEN+1){1'b0}};
            col_q   <= {(ROW_LEN+1){1'b0}};
            row_q   <= 1'b0;
            addr_q  <= {CB_AW{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
            grp_q   <= {ROW_LEN{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cs_q    <= cs_d;
            ce_q    <= ce_d;
            eff_q   <= eff_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
            grp_q   <= grp_d;
`endif
        end
    end

    assign addr_out   = addr_q;
    assign row_sel    = row_q;
    assign col_out    = col_q;
    assign addr_valid = valid_q;
    assign last       = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cb_row_agd.sv
// ---------------------------------------------------------------------------
// tb_cb_row_agd -- scoreboard bench for cb_row_agd
// Stimulus pushes the expected beats of each burst into a queue; a monitor
// on the falling edge pops and compares every presented beat.
// ---------------------------------------------------------------------------
module tb_cb_row_agd;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] base_addr = 17'd0;
    logic [9:0]  group_cnt = 10'd0;
    logic [10:0] col_start = 11'd0;
    logic [10:0] col_end = 11'd0;
    logic [16:0] addr_out;
    logic        row_sel;
    logic [10:0] col_out;
    logic        addr_valid;
    logic        addr_ready = 1'b1;
    logic        last;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [16:0] a;
        logic        r;
        logic [10:0] c;
        logic        l;
    } beat_t;

    beat_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int fv_cyc = -1;

    cb_row_agd #(.CB_AW(17), .ROW_LEN(10)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start),
        .base_addr(base_addr), .group_cnt(group_cnt),
        .col_start(col_start), .col_end(col_end),
        .addr_out(addr_out), .row_sel(row_sel), .col_out(col_out),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .last(last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: compare every presented beat against the queue head
    always @(negedge clk) begin
        beat_t e;
        if (addr_valid) begin
            if (fv_cyc < 0) fv_cyc = cyc;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL beat_unexpected got addr=%0d row=%0d col=%0d", addr_out, row_sel, col_out);
            end else begin
                e = sb[0];
                if (addr_out !== e.a || row_sel !== e.r || col_out !== e.c || last !== e.l) begin
                    errors = errors + 1;
                    $display("FAIL beat got addr=%0d row=%0d col=%0d last=%0d expected addr=%0d row=%0d col=%0d last=%0d",
                             addr_out, row_sel, col_out, last, e.a, e.r, e.c, e.l);
                end
                if (addr_ready) void'(sb.pop_front());
            end
            if (addr_ready) hs_cnt = hs_cnt + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // expected beats of one burst
    task automatic push_model(input logic [16:0] b, input logic [9:0] g,
                              input logic [10:0] cs, input logic [10:0] ce,
                              output int n, output logic e);
        logic [10:0] eff;
        logic [10:0] lim;
        beat_t bt;
        eff = ce;
        e = 1'b0;
        lim = {g, 1'b1};
`ifdef CB_ROW_AGD_BOUND_CHECK_EN
        if (ce > lim) begin
            eff = lim;
            e = 1'b1;
        end
`endif
        n = 0;
        if (cs <= eff) begin
            for (int c = int'(cs); c <= int'(eff); c++) begin
                for (int r = 0; r < 2; r++) begin
                    bt.a = 17'(int'(b) + 2 * c + r);
                    bt.r = r[0];
                    bt.c = 11'(c);
                    bt.l = (c == int'(eff)) && (r == 1);
                    sb.push_back(bt);
                    n++;
                end
            end
        end
    endtask

    task automatic run_burst(input string name, input logic [16:0] b, input logic [9:0] g,
                             input logic [10:0] cs, input logic [10:0] ce,
                             input int stall_beat, input int stall_len, input int abort_beat);
        int n;
        logic exp_err;
        int hs0;
        int d0;
        int start_cyc;
        int stalled;
        int guard;
        push_model(b, g, cs, ce, n, exp_err);
        hs0 = hs_cnt;
        d0 = done_cnt;
        fv_cyc = -1;
        base_addr = b;
        group_cnt = g;
        col_start = cs;
        col_end = ce;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_calc_busy"}, int'(busy), 1);
        chk({name, "_calc_novalid"}, int'(addr_valid), 0);
        @(posedge clk); #1;
        chk({name, "_valid_t2"}, int'(addr_valid), (n > 0) ? 1 : 0);
        if (n > 0) begin
            // request while busy must be ignored
            start = 1'b1;
            base_addr = 17'd1000;
            group_cnt = 10'd5;
            col_start = 11'd0;
            col_end = 11'd9;
        end
        stalled = 0;
        guard = 0;
        while (!done && guard < 400) begin
            if (abort_beat >= 0 && addr_valid && (hs_cnt - hs0) == abort_beat) begin
                addr_ready = 1'b0;
                sys_rst = 1'b1;
                @(posedge clk); #1;
                sys_rst = 1'b0;
                addr_ready = 1'b1;
                sb.delete();
                chk({name, "_rst_valid"}, int'(addr_valid), 0);
                chk({name, "_rst_busy"}, int'(busy), 0);
                chk({name, "_rst_addr"}, int'(addr_out), 0);
                chk({name, "_rst_last"}, int'(last), 0);
                @(posedge clk); #1;
                chk({name, "_rst_nodone"}, done_cnt, d0);
                return;
            end
            if (addr_valid && (hs_cnt - hs0) == stall_beat && stalled < stall_len) begin
                addr_ready = 1'b0;
                stalled++;
            end else begin
                addr_ready = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        addr_ready = 1'b1;
        if (guard >= 400) chk({name, "_timeout"}, 1, 0);
        chk({name, "_err"}, int'(err), int'(exp_err));
        @(posedge clk); #1;
        chk({name, "_done_lat"}, done_cyc - start_cyc, (n == 0) ? 2 : 2 + n + stalled);
        if (n > 0) chk({name, "_first_valid"}, fv_cyc - start_cyc, 2);
        chk({name, "_beats"}, hs_cnt - hs0, n);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_one_done"}, done_cnt - d0, 1);
        chk({name, "_idle_busy"}, int'(busy), 0);
        chk({name, "_idle_done"}, int'(done), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", int'(addr_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_addr", int'(addr_out), 0);
        chk("reset_col", int'(col_out), 0);
        sys_rst = 1'b0;
        @(posedge clk); #1;

        // g=0: addr 0..3, done at T+6
        run_burst("g0", 17'd0, 10'd0, 11'd0, 11'd1, -1, 0, -1);
        // g=3: addr 28..33
        run_burst("g3", 17'd24, 10'd3, 11'd2, 11'd4, -1, 0, -1);
        // g=3 with 3 stall cycles on the third beat (addr 30)
        run_burst("g3_stall", 17'd24, 10'd3, 11'd2, 11'd4, 2, 3, -1);
        // empty range
        run_burst("empty", 17'd24, 10'd3, 11'd5, 11'd4, -1, 0, -1);
        // col_end beyond 2*g+1
        run_burst("bound", 17'd4, 10'd1, 11'd0, 11'd7, -1, 0, -1);
        // next accepted start clears err
        run_burst("g0_again", 17'd0, 10'd0, 11'd0, 11'd1, -1, 0, -1);
        // address wraps modulo 2^17
        run_burst("wrap", 17'h1FFFE, 10'd100, 11'd0, 11'd1, -1, 0, -1);
        // reset on the fourth beat, then a clean burst
        run_burst("abort", 17'd24, 10'd3, 11'd2, 11'd4, -1, 0, 3);
        run_burst("after_abort", 17'd24, 10'd3, 11'd2, 11'd4, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_row_agd.md
CB_ROW_AGD -- requirements
Module: cb_row_agd

Interface
REQ-001 Parameter CB_AW, default 17, covariance-buffer address width.
REQ-002 Parameter ROW_LEN, default 10, group-count width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 sys_rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 base_addr  input  CB_AW  group base address from the upstream base generator, value 2*(g*g+g) for group g.
REQ-007 group_cnt  input  ROW_LEN  group index g.
REQ-008 col_start  input  ROW_LEN+1  first column, inclusive.
REQ-009 col_end  input  ROW_LEN+1  last column, inclusive.
REQ-010 addr_out  output  CB_AW  generated buffer address.
REQ-011 row_sel  output  1  row within the group pair (0 or 1) for the current beat.
REQ-012 col_out  output  ROW_LEN+1  column for the current beat.
REQ-013 addr_valid  output  1  addr_out, row_sel and col_out are valid.
REQ-014 addr_ready  input  1  downstream accepts the beat when high with addr_valid.
REQ-015 last  output  1  high with the final beat of a burst.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 err  output  1  sticky range-error flag, cleared by the next accepted start.

Function
REQ-019 FSM states: IDLE, CALC, RUN, DONE.
REQ-020 IDLE->CALC when start=1; base_addr, group_cnt, col_start and col_end are registered in that same cycle.
REQ-021 CALC lasts one cycle: computes limit=2*g+1 and the effective end column; goes to RUN, or to DONE if col_start > effective end.
REQ-022 In RUN the beat order is: for col from col_start to the effective end, row 0 then row 1.
REQ-023 addr_out = base + 2*col + row_sel, truncated modulo 2^CB_AW.
REQ-024 First addr_valid asserts 2 cycles after the start cycle (start at T, CALC at T+1, valid at T+2).
REQ-025 A beat completes on addr_valid & addr_ready; the next beat presents in the following cycle with no bubble.
REQ-026 While addr_ready=0, addr_out, row_sel, col_out and last hold stable and addr_valid stays high.
REQ-027 last=1 only on the beat with col = effective end and row_sel=1.
REQ-028 The handshake of the last beat moves RUN->DONE; DONE asserts done for one cycle and then returns to IDLE.
REQ-029 A zero-beat burst (col_start > effective end) produces no addr_valid; done pulses at T+2.
REQ-030 start while busy=1 is ignored and does not alter the burst in progress.
REQ-031 A back-to-back start is accepted in the IDLE cycle immediately after DONE.

Reset
REQ-032 sys_rst=1 forces IDLE and clears addr_out, row_sel, col_out, addr_valid, last, busy, done, err and all internal registers to 0.
REQ-033 Reset during RUN aborts the burst immediately: no done, no further beats; the block is ready for start in the first cycle after reset deasserts.

Configuration
REQ-034 Macro CB_ROW_AGD_BOUND_CHECK_EN defined: if col_end > 2*g+1, the effective end is clamped to 2*g+1 and err is set in CALC.
REQ-035 Macro undefined: the effective end is col_end unchecked, and err is tied to 0.

Verification
REQ-036 g=0, base=0, cols 0..1, ready=1 -> addr 0,1,2,3 on consecutive cycles T+2..T+5, last on 3, done at T+6.
REQ-037 g=3, base=24, cols 2..4, ready=1 -> addr 28,29,30,31,32,33, row_sel alternating 0/1, col_out 2,2,3,3,4,4.
REQ-038 g=3, base=24, cols 2..4, ready low for 3 cycles on the third beat -> addr_out held at 30 for those cycles, sequence unchanged, no beat lost.
REQ-039 col_start=5, col_end=4 -> no addr_valid, done pulse at T+2, busy low from T+3.
REQ-040 BOUND_CHECK_EN: g=1, base=4, cols 0..7 -> addr 4..11, err=1; without the macro -> addr 4..19, err=0.
REQ-041 sys_rst asserted on the fourth beat of REQ-037, then start issued two cycles later -> no done from the aborted burst, new burst starts cleanly from its first address.
